// File: rtl/btn_cmd_pkg.sv
// ---------------------------------------------------------------------------
// btn_cmd_pkg
//  Shared types and defaults for the button command arbiter.
//  - state_e        : arbiter FSM states (IDLE, ISSUE, WAIT_DONE)
//  - DEF_NUM_REQ    : default number of requesters
//  - DEF_TIMEOUT_CYC: default WAIT_DONE abort limit (used with BTN_TIMEOUT_EN)
// ---------------------------------------------------------------------------
package btn_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//  Combinational round-robin picker. Searches pending_i upward starting at
//  last_grant_i + 1, wrapping NUM_REQ-1 -> 0, and returns the first set bit.
//  Ports:
//   pending_i     in  NUM_REQ  outstanding requests
//   last_grant_i  in  CMD_W    index granted most recently
//   winner_o      out CMD_W    selected index (0 when nothing pending)
//   any_valid_o   out 1        at least one request pending
// ---------------------------------------------------------------------------
module rr_pick
    import btn_cmd_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int CMD_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pending_i,
    input  logic [CMD_W-1:0]   last_grant_i,
    output logic [CMD_W-1:0]   winner_o,
    output logic               any_valid_o
);

    localparam logic [CMD_W:0] NUM_REQ_W = (CMD_W+1)'(NUM_REQ);

    // cand[gi] is the requester examined at search position gi (gi=0 first).
    logic [CMD_W-1:0]   cand [NUM_REQ];
    logic [NUM_REQ-1:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [CMD_W:0] sum;
            logic [CMD_W:0] wrapped;
            // last_grant + gi + 1 never exceeds 2*NUM_REQ-1, so one
            // conditional subtraction is enough to wrap.
            assign sum       = {1'b0, last_grant_i} + (CMD_W+1)'(gi + 1);
            assign wrapped   = (sum >= NUM_REQ_W) ? (sum - NUM_REQ_W) : sum;
            assign cand[gi]  = wrapped[CMD_W-1:0];
            assign hit[gi]   = pending_i[cand[gi]];
        end
    endgenerate

    // Descending scan so the earliest search position overwrites later ones.
    always_comb begin
        winner_o    = '0;
        any_valid_o = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                winner_o    = cand[k];
                any_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/btn_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// btn_cmd_arbiter
//  Latches single-cycle request pulses from the button one-shot bank and
//  issues them one at a time, round-robin, as commands to the matrix-vector
//  sequencer. A new command is only offered after op_done for the previous.
//  Optional macro BTN_TIMEOUT_EN: abort WAIT_DONE after TIMEOUT_CYC cycles
//  without op_done and pulse timeout_err.
//  Ports:
//   clk          in   1        clock, all logic on posedge
//   reset        in   1        synchronous active-high reset
//   req_pulse    in   NUM_REQ  one-cycle request pulses
//   cmd_valid    out  1        command offered
//   cmd_id       out  CMD_W    granted requester index
//   cmd_ready    in   1        datapath accepts command
//   op_done      in   1        accepted command finished (pulse)
//   busy         out  1        FSM not in IDLE
//   pending      out  NUM_REQ  latched outstanding requests
//   timeout_err  out  1        pulse on WAIT_DONE abort
// ---------------------------------------------------------------------------
module btn_cmd_arbiter
    import btn_cmd_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int CMD_W       = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_pulse,
    output logic               cmd_valid,
    output logic [CMD_W-1:0]   cmd_id,
    input  logic               cmd_ready,
    input  logic               op_done,
    output logic               busy,
    output logic [NUM_REQ-1:0] pending,
    output logic               timeout_err
);

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [NUM_REQ-1:0] clear_mask;
    logic               cmd_valid_q, cmd_valid_d;
    logic [CMD_W-1:0]   cmd_id_q, cmd_id_d;
    logic [CMD_W-1:0]   last_grant_q, last_grant_d;
    logic               timeout_err_q, timeout_err_d;
    logic [CMD_W-1:0]   pick_idx;
    logic               pick_any;
    logic               timeout_hit;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .CMD_W   (CMD_W)
    ) u_rr_pick (
        .pending_i    (pending_q),
        .last_grant_i (last_grant_q),
        .winner_o     (pick_idx),
        .any_valid_o  (pick_any)
    );

`ifdef BTN_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Counts only while waiting; any other state holds it at zero, so every
    // WAIT_DONE entry starts from 0.
    assign wait_cnt_d  = (state_q == WAIT_DONE) ? wait_cnt_q + 1'b1 : '0;
    assign timeout_hit = (state_q == WAIT_DONE) && (wait_cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        cmd_valid_d   = cmd_valid_q;
        cmd_id_d      = cmd_id_q;
        last_grant_d  = last_grant_q;
        timeout_err_d = 1'b0;
        clear_mask    = '0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d      = ISSUE;
                    cmd_valid_d  = 1'b1;
                    cmd_id_d     = pick_idx;
                    last_grant_d = pick_idx;
                end
            end
            ISSUE: begin
                if (cmd_valid_q && cmd_ready) begin
                    state_d              = WAIT_DONE;
                    cmd_valid_d          = 1'b0;
                    clear_mask[cmd_id_q] = 1'b1;
                end
            end
            WAIT_DONE: begin
                // op_done takes priority over a timeout in the same cycle.
                if (op_done) begin
                    state_d = IDLE;
                end else if (timeout_hit) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                cmd_valid_d = 1'b0;
            end
        endcase
        // New pulses are OR'ed in after the grant clear so a pulse on the
        // handshake cycle re-queues the request.
        pending_d = (pending_q & ~clear_mask) | req_pulse;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pending_q     <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_id_q      <= '0;
            last_grant_q  <= CMD_W'(NUM_REQ - 1);
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_id_q      <= cmd_id_d;
            last_grant_q  <= last_grant_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign cmd_valid   = cmd_valid_q;
    assign cmd_id      = cmd_id_q;
    assign busy        = (state_q != IDLE);
    assign pending     = pending_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_btn_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_btn_cmd_arbiter
//  Directed scenarios plus randomized traffic for btn_cmd_arbiter, compared
//  every cycle against a behavioural model of the arbiter.
// ---------------------------------------------------------------------------
module tb_btn_cmd_arbiter;

    localparam int NUM_REQ = 4;
    localparam int TO_CYC  = 8;
    localparam int CMD_W   = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [NUM_REQ-1:0] req_pulse;
    logic               cmd_valid;
    logic [CMD_W-1:0]   cmd_id;
    logic               cmd_ready;
    logic               op_done;
    logic               busy;
    logic [NUM_REQ-1:0] pending;
    logic               timeout_err;

    always #5 clk = ~clk;

    btn_cmd_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .TIMEOUT_CYC (TO_CYC),
        .CMD_W       (CMD_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_pulse   (req_pulse),
        .cmd_valid   (cmd_valid),
        .cmd_id      (cmd_id),
        .cmd_ready   (cmd_ready),
        .op_done     (op_done),
        .busy        (busy),
        .pending     (pending),
        .timeout_err (timeout_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [NUM_REQ-1:0] m_pend;
    bit               m_offer;   // command currently offered
    bit               m_wait;    // command accepted, waiting for completion
    int               m_id;
    int               m_last;
    int               m_cnt;
    bit               m_terr;

    function automatic int rr_next(input bit [NUM_REQ-1:0] p, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int i;
            i = (last + k) % NUM_REQ;
            if (p[i]) return i;
        end
        return 0;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_advance();
        bit [NUM_REQ-1:0] np;
        if (reset) begin
            m_pend = '0; m_offer = 0; m_wait = 0; m_id = 0;
            m_last = NUM_REQ - 1; m_cnt = 0; m_terr = 0;
            return;
        end
        np     = m_pend;
        m_terr = 0;
        if (m_offer && cmd_ready) np[m_id] = 1'b0;
        np = np | req_pulse;
        if (!m_offer && !m_wait) begin
            if (m_pend != 0) begin
                m_id    = rr_next(m_pend, m_last);
                m_last  = m_id;
                m_offer = 1;
            end
        end else if (m_offer) begin
            if (cmd_ready) begin
                m_offer = 0;
                m_wait  = 1;
                m_cnt   = 0;
            end
        end else begin
            if (op_done) begin
                m_wait = 0;
            end
`ifdef BTN_TIMEOUT_EN
            else if (m_cnt == TO_CYC - 1) begin
                m_wait = 0;
                m_terr = 1;
            end else begin
                m_cnt++;
            end
`endif
        end
        m_pend = np;
    endtask

    // One clock: update model, wait for edge, compare all outputs.
    task automatic step();
        model_advance();
        @(posedge clk);
        #1;
        check_eq("busy",    32'(busy),        32'(m_offer || m_wait));
        check_eq("valid",   32'(cmd_valid),   32'(m_offer));
        check_eq("id",      32'(cmd_id),      32'(m_id));
        check_eq("pending", 32'(pending),     32'(m_pend));
        check_eq("terr",    32'(timeout_err), 32'(m_terr));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_ids[$];
        int done_cd;

        reset = 1'b1; req_pulse = '0; cmd_ready = 1'b0; op_done = 1'b0;
        step();
        reset = 1'b0;

        // Reset state
        check_eq("rst_pending", 32'(pending),     32'h0);
        check_eq("rst_valid",   32'(cmd_valid),   32'h0);
        check_eq("rst_busy",    32'(busy),        32'h0);
        check_eq("rst_id",      32'(cmd_id),      32'h0);
        check_eq("rst_terr",    32'(timeout_err), 32'h0);

        // Single request on requester 2
        req_pulse = 4'b0100; step();
        check_eq("single_pend_t1",  32'(pending),   32'h4);
        check_eq("single_valid_t1", 32'(cmd_valid), 32'h0);
        req_pulse = '0; step();
        check_eq("single_valid_t2", 32'(cmd_valid), 32'h1);
        check_eq("single_id_t2",    32'(cmd_id),    32'h2);
        cmd_ready = 1'b1; step();
        check_eq("single_pend_acc", 32'(pending),   32'h0);
        check_eq("single_busy_acc", 32'(busy),      32'h1);
        cmd_ready = 1'b0; op_done = 1'b1; step();
        check_eq("single_idle",     32'(busy),      32'h0);
        op_done = 1'b0;

        // Fairness: all four at once, op_done 3 cycles after each accept
        do_reset();
        req_pulse = 4'hF; step();
        req_pulse = '0; cmd_ready = 1'b1; done_cd = -1;
        for (int c = 0; c < 40; c++) begin
            op_done = 1'b0;
            if (done_cd > 0) begin
                done_cd--;
                if (done_cd == 0) op_done = 1'b1;
            end
            if (cmd_valid && cmd_ready) begin
                acc_ids.push_back(int'(cmd_id));
                done_cd = 3;
            end
            step();
        end
        cmd_ready = 1'b0; op_done = 1'b0;
        check_eq("fair_count", 32'(acc_ids.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_eq("fair_order", (i < acc_ids.size()) ? 32'(acc_ids[i]) : 32'hFFFF_FFFF, 32'(i));
        end

        // Backpressure: ready held low for 10 cycles
        do_reset();
        req_pulse = 4'b0010; step();
        req_pulse = '0; step();
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("bp_valid", 32'(cmd_valid), 32'h1);
            check_eq("bp_id",    32'(cmd_id),    32'h1);
        end
        cmd_ready = 1'b1; step();
        cmd_ready = 1'b0; op_done = 1'b1; step();
        op_done = 1'b0;

        // Re-queue: pulse requester 1 on its own handshake cycle
        do_reset();
        req_pulse = 4'b0010; step();
        req_pulse = '0; step();
        cmd_ready = 1'b1; req_pulse = 4'b0010; step();
        check_eq("rq_pend",  32'(pending),   32'h2);
        check_eq("rq_valid", 32'(cmd_valid), 32'h0);
        cmd_ready = 1'b0; req_pulse = '0; op_done = 1'b1; step();
        check_eq("rq_idle",  32'(busy),      32'h0);
        op_done = 1'b0; step();
        check_eq("rq_reissue_valid", 32'(cmd_valid), 32'h1);
        check_eq("rq_reissue_id",    32'(cmd_id),    32'h1);
        cmd_ready = 1'b1; step();
        cmd_ready = 1'b0; op_done = 1'b1; step();
        op_done = 1'b0;

        // WAIT_DONE without op_done
        do_reset();
        req_pulse = 4'b0001; step();
        req_pulse = '0; step();
        cmd_ready = 1'b1; step();
        cmd_ready = 1'b0;
`ifdef BTN_TIMEOUT_EN
        for (int i = 0; i < TO_CYC - 1; i++) begin
            step();
            check_eq("to_wait_busy", 32'(busy), 32'h1);
        end
        step();
        check_eq("to_idle", 32'(busy),        32'h0);
        check_eq("to_terr", 32'(timeout_err), 32'h1);
        step();
        check_eq("to_terr_pulse", 32'(timeout_err), 32'h0);
`else
        for (int i = 0; i < 20; i++) step();
        check_eq("nowait_busy", 32'(busy),        32'h1);
        check_eq("nowait_terr", 32'(timeout_err), 32'h0);
        op_done = 1'b1; step();
        check_eq("nowait_done", 32'(busy),        32'h0);
        op_done = 1'b0;
`endif

        // Reset while in WAIT_DONE with three requests pending
        do_reset();
        req_pulse = 4'b0111; step();
        req_pulse = '0; step();
        cmd_ready = 1'b1; step();
        cmd_ready = 1'b0; req_pulse = 4'b1000; step();
        check_eq("mrst_pend_before", 32'(pending), 32'hE);
        req_pulse = '0; reset = 1'b1; step();
        check_eq("mrst_busy",    32'(busy),      32'h0);
        check_eq("mrst_pending", 32'(pending),   32'h0);
        check_eq("mrst_valid",   32'(cmd_valid), 32'h0);
        reset = 1'b0; op_done = 1'b1; step();
        check_eq("mrst_done_ignored", 32'(busy), 32'h0);
        op_done = 1'b0;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            req_pulse = ($urandom_range(0, 3) == 0) ? NUM_REQ'($urandom_range(0, 15)) : '0;
            cmd_ready = ($urandom_range(0, 2) != 0);
            op_done   = ($urandom_range(0, 11) == 0);
            reset     = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0; req_pulse = '0; cmd_ready = 1'b0; op_done = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
